// File: rtl/multi_counter_sum.sv
// multi_counter_sum
//   NUM_CH independent step counters feeding a registered pairwise adder tree.
//   The tree keeps full precision. sum is the low WIDTH bits of the total.
//   overflow is a sticky flag that sets whenever the total's upper bits are nonzero.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; release is synchronous to clk
//   ch_en      in   per-channel count enable
//   ch_clear   in   per-channel synchronous clear; takes priority over ch_en
//   step       in   increment added to every enabled channel
//   ovf_clear  in   clears the sticky overflow flag; a same-cycle set wins
//   count_flat out  counter values; channel i at [i*WIDTH +: WIDTH]
//   sum        out  low WIDTH bits of the sum of all counters (LEVELS cycles later)
//   sum_valid  out  high once the tree pipeline holds real counts after reset
//   overflow   out  sticky: a tree total exceeded 2^WIDTH-1
module multi_counter_sum #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ch_clear,
    input  logic [STEP_W-1:0]        step,
    input  logic                     ovf_clear,
    output logic [NUM_CH*WIDTH-1:0]  count_flat,
    output logic [WIDTH-1:0]         sum,
    output logic                     sum_valid,
    output logic                     overflow
);

    localparam int unsigned LEVELS = $clog2(NUM_CH);
    localparam int unsigned TW     = WIDTH + LEVELS;

    logic [WIDTH-1:0]  r_count      [NUM_CH];
    logic [WIDTH-1:0]  w_count_next [NUM_CH];
    logic [WIDTH:0]    w_add        [NUM_CH];

    // Heap-ordered tree: node n adds children 2n and 2n+1; leaves occupy
    // indices NUM_CH..2*NUM_CH-1 and are the counters themselves. Every path
    // from leaf to root crosses LEVELS registers, so the tree stays balanced.
    logic [TW-1:0]     r_node       [1:NUM_CH-1];
    logic [TW-1:0]     w_node_next  [1:NUM_CH-1];
    logic [TW-1:0]     w_val        [2:2*NUM_CH-1];

    logic [LEVELS-1:0] r_vld;
    logic [LEVELS-1:0] w_vld_next;
    logic              r_ovf;
    logic              w_ovf_next;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_add[i]        = {1'b0, r_count[i]} + (WIDTH+1)'(step);
            w_count_next[i] = r_count[i];
            if (ch_clear[i]) begin
                w_count_next[i] = '0;
            end else if (ch_en[i]) begin
                if ((SATURATE != 0) && w_add[i][WIDTH]) begin
                    w_count_next[i] = '1;
                end else begin
                    w_count_next[i] = w_add[i][WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned n = 2; n < NUM_CH; n++) begin
            w_val[n] = r_node[n];
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_val[NUM_CH+i] = TW'(r_count[i]);
        end
        for (int unsigned n = 1; n < NUM_CH; n++) begin
            w_node_next[n] = w_val[2*n] + w_val[2*n+1];
        end
    end

    // Overflow is judged on the total entering the root register so the flag
    // rises on the same edge that sum shows the truncated value.
    always_comb begin
        w_ovf_next = (r_ovf && !ovf_clear) || (|w_node_next[1][TW-1:WIDTH]);
    end

    always_comb begin
        w_vld_next    = r_vld << 1;
        w_vld_next[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_count[i] <= '0;
            end
            for (int unsigned n = 1; n < NUM_CH; n++) begin
                r_node[n] <= '0;
            end
            r_vld <= '0;
            r_ovf <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_count[i] <= w_count_next[i];
            end
            for (int unsigned n = 1; n < NUM_CH; n++) begin
                r_node[n] <= w_node_next[n];
            end
            r_vld <= w_vld_next;
            r_ovf <= w_ovf_next;
        end
    end

    always_comb begin
        count_flat = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            count_flat[i*WIDTH +: WIDTH] = r_count[i];
        end
    end

    assign sum       = r_node[1][WIDTH-1:0];
    assign sum_valid = r_vld[LEVELS-1];
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_multi_counter_sum.sv
module tb_multi_counter_sum;

    logic         clk;
    logic         rst_n;
    logic [3:0]   ch_en;
    logic [3:0]   ch_clear;
    logic [7:0]   step;
    logic         ovf_clear;

    logic [127:0] a_flat;
    logic [31:0]  a_sum;
    logic         a_valid;
    logic         a_ovf;

    logic [31:0]  b_flat;
    logic [7:0]   b_sum;
    logic         b_valid;
    logic         b_ovf;

    logic [31:0]  c_flat;
    logic [7:0]   c_sum;
    logic         c_valid;
    logic         c_ovf;

    int n_checks = 0;
    int n_errors = 0;

    multi_counter_sum #(.WIDTH(32), .NUM_CH(4), .STEP_W(8), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_clear(ch_clear), .step(step),
        .ovf_clear(ovf_clear), .count_flat(a_flat), .sum(a_sum),
        .sum_valid(a_valid), .overflow(a_ovf)
    );

    multi_counter_sum #(.WIDTH(8), .NUM_CH(4), .STEP_W(8), .SATURATE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_clear(ch_clear), .step(step),
        .ovf_clear(ovf_clear), .count_flat(b_flat), .sum(b_sum),
        .sum_valid(b_valid), .overflow(b_ovf)
    );

    multi_counter_sum #(.WIDTH(8), .NUM_CH(4), .STEP_W(8), .SATURATE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_clear(ch_clear), .step(step),
        .ovf_clear(ovf_clear), .count_flat(c_flat), .sum(c_sum),
        .sum_valid(c_valid), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  clr;
        logic [7:0]  stp;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [31:0] c3;
        logic [31:0] sum;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] clr, input logic [7:0] stp,
                                input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input logic [31:0] s);
        vec_t v;
        v.en = en; v.clr = clr; v.stp = stp;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.sum = s;
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        ch_en     = '0;
        ch_clear  = '0;
        step      = '0;
        ovf_clear = 1'b0;

        // Ten enabled cycles with step 1; sum trails counts by two edges.
        for (int r = 1; r <= 10; r++) begin
            tbl[r-1] = mk(4'hF, 4'h0, 8'd1, r, r, r, r, (r > 2) ? 4*(r-2) : 0);
        end
        tbl[10] = mk(4'h0, 4'h0, 8'd0,  10, 10, 10, 10,  36);
        tbl[11] = mk(4'h0, 4'h0, 8'd0,  10, 10, 10, 10,  40);
        tbl[12] = mk(4'hF, 4'h4, 8'd1,  11, 11,  0, 11,  40);
        tbl[13] = mk(4'hF, 4'h0, 8'd1,  12, 12,  1, 12,  40);
        tbl[14] = mk(4'h0, 4'h0, 8'd0,  12, 12,  1, 12,  33);
        tbl[15] = mk(4'h0, 4'h0, 8'd0,  12, 12,  1, 12,  37);
        tbl[16] = mk(4'h0, 4'h0, 8'd0,  12, 12,  1, 12,  37);
        tbl[17] = mk(4'hF, 4'h0, 8'd0,  12, 12,  1, 12,  37);
        tbl[18] = mk(4'h1, 4'h0, 8'hFF, 267, 12,  1, 12,  37);
        tbl[19] = mk(4'h0, 4'h0, 8'd0, 267, 12,  1, 12,  37);
        tbl[20] = mk(4'h0, 4'h0, 8'd0, 267, 12,  1, 12, 292);

        // Reset state, asynchronous
        #1;
        check("rst_flat", a_flat, '0);
        check("rst_sum", a_sum, '0);
        check("rst_valid", a_valid, 1'b0);
        check("rst_ovf", a_ovf, 1'b0);
        repeat (2) tick();
        check("rst_hold_valid", a_valid, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_e1_valid", a_valid, 1'b0);
        check("idle_e1_sum", a_sum, '0);
        check("idle_e1_flat", a_flat, '0);
        tick();
        check("idle_e2_valid", a_valid, 1'b1);
        check("idle_e2_sum", a_sum, '0);
        check("idle_e2_flat", a_flat, '0);

        // Table-driven count/clear/sum sequence on the 32-bit instance
        for (int r = 0; r < 21; r++) begin
            ch_en    = tbl[r].en;
            ch_clear = tbl[r].clr;
            step     = tbl[r].stp;
            tick();
            check($sformatf("row%0d_c0", r+1), a_flat[31:0],   tbl[r].c0);
            check($sformatf("row%0d_c1", r+1), a_flat[63:32],  tbl[r].c1);
            check($sformatf("row%0d_c2", r+1), a_flat[95:64],  tbl[r].c2);
            check($sformatf("row%0d_c3", r+1), a_flat[127:96], tbl[r].c3);
            check($sformatf("row%0d_sum", r+1), a_sum, tbl[r].sum);
            check($sformatf("row%0d_valid", r+1), a_valid, 1'b1);
            check($sformatf("row%0d_ovf", r+1), a_ovf, 1'b0);
        end

        // Short reset pulse mid-count, no clock edge inside it
        @(negedge clk);
        ch_en = '0; ch_clear = '0; step = '0;
        #2 rst_n = 1'b0;
        #1;
        check("pulse_flat", a_flat, '0);
        check("pulse_sum", a_sum, '0);
        check("pulse_valid", a_valid, 1'b0);
        check("pulse_b_flat", b_flat, '0);
        #1 rst_n = 1'b1;
        tick();
        check("pulse_e1_valid", a_valid, 1'b0);
        check("pulse_e1_sum", a_sum, '0);
        tick();
        check("pulse_e2_valid", a_valid, 1'b1);

        // Wrap (b) versus clamp (c) at WIDTH=8
        ch_en = 4'b0011; step = 8'h80;
        tick();
        check("e1_b_c0", b_flat[7:0], 8'h80);
        check("e1_b_c1", b_flat[15:8], 8'h80);
        check("e1_c_c0", c_flat[7:0], 8'h80);
        tick();
        check("e2_b_c0", b_flat[7:0], 8'h00);
        check("e2_b_ovf", b_ovf, 1'b0);
        check("e2_c_c0", c_flat[7:0], 8'hFF);
        check("e2_c_c1", c_flat[15:8], 8'hFF);
        check("e2_c_ovf", c_ovf, 1'b0);
        tick();
        check("e3_b_c0", b_flat[7:0], 8'h80);
        check("e3_b_sum", b_sum, 8'h00);
        check("e3_b_ovf", b_ovf, 1'b1);
        check("e3_c_c0", c_flat[7:0], 8'hFF);
        check("e3_c_sum", c_sum, 8'h00);
        check("e3_c_ovf", c_ovf, 1'b1);
        ch_en = '0;
        tick();
        check("e4_b_sum", b_sum, 8'h00);
        check("e4_b_ovf", b_ovf, 1'b1);
        check("e4_c_sum", c_sum, 8'hFE);
        ovf_clear = 1'b1;
        tick();
        check("e5_b_ovf", b_ovf, 1'b1);
        check("e5_c_sum", c_sum, 8'hFE);
        check("e5_c_ovf", c_ovf, 1'b1);
        ch_clear = 4'b0011;
        tick();
        check("e6_b_c0", b_flat[7:0], 8'h00);
        check("e6_c_c0", c_flat[7:0], 8'h00);
        check("e6_c_sum", c_sum, 8'hFE);
        check("e6_c_ovf", c_ovf, 1'b1);
        ch_clear = '0;
        tick();
        check("e7_b_ovf", b_ovf, 1'b1);
        check("e7_c_ovf", c_ovf, 1'b1);
        tick();
        check("e8_b_ovf", b_ovf, 1'b0);
        check("e8_b_sum", b_sum, 8'h00);
        check("e8_c_ovf", c_ovf, 1'b0);
        check("e8_c_sum", c_sum, 8'h00);
        check("e8_c_valid", c_valid, 1'b1);
        check("e8_b_valid", b_valid, 1'b1);
        ovf_clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
